// File: rtl/alu_seq_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_unit
//  Description : Registered ALU with start/done handshake. AND/OR/XOR/ADD/SUB
//                complete in one cycle. Shifts (SLL/SRA/SRL) step one bit per
//                cycle unless ALU_FAST_SHIFT_EN is defined, which selects a
//                single-cycle barrel shifter and removes the SHIFT state.
//                Result and {N,Z,C,V} flags are registered together and
//                announced with a one-cycle DONE pulse.
//  Options     : ALU_FAST_SHIFT_EN (undefined = iterative shifter)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [2:0]       ALUSEL,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] ALUOut,
    output logic [3:0]       FLAGS
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] c_OP_AND = 3'b000;
    localparam logic [2:0] c_OP_OR  = 3'b001;
    localparam logic [2:0] c_OP_SUB = 3'b010;
    localparam logic [2:0] c_OP_ADD = 3'b011;
    localparam logic [2:0] c_OP_SLL = 3'b100;
    localparam logic [2:0] c_OP_SRA = 3'b101;
    localparam logic [2:0] c_OP_SRL = 3'b110;
    localparam logic [2:0] c_OP_XOR = 3'b111;

    // Pack {N,Z,C,V} from a result and its carry/overflow bits
    function automatic logic [3:0] f_flags(input logic [WIDTH-1:0] res,
                                           input logic             c,
                                           input logic             v);
        f_flags = {res[WIDTH-1], (res == '0), c, v};
    endfunction

    logic [SHW-1:0]   w_n;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;

    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;
    logic             r_done;

    assign w_n    = B[SHW-1:0];
    assign w_sum  = {1'b0, A} + {1'b0, B};
    assign w_diff = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};

`ifdef ALU_FAST_SHIFT_EN

    // Extra bit below/above the operand catches the last bit shifted out;
    // for a zero shift that bit stays 0, which is the required carry.
    logic [WIDTH:0] w_lext;
    logic [WIDTH:0] w_rext;

    // Single-cycle result for every operation, barrel shifter included
    always_comb begin
        w_res  = '0;
        w_c    = 1'b0;
        w_v    = 1'b0;
        w_lext = '0;
        w_rext = '0;
        case (ALUSEL)
            c_OP_AND: w_res = A & B;
            c_OP_OR:  w_res = A | B;
            c_OP_XOR: w_res = A ^ B;
            c_OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_c   = w_diff[WIDTH];
                w_v   = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
            end
            c_OP_SLL: begin
                w_lext = {1'b0, A} << w_n;
                w_res  = w_lext[WIDTH-1:0];
                w_c    = w_lext[WIDTH];
            end
            c_OP_SRA: begin
                w_rext = $signed({A, 1'b0}) >>> w_n;
                w_res  = w_rext[WIDTH:1];
                w_c    = w_rext[0];
            end
            default: begin
                w_rext = {A, 1'b0} >> w_n;
                w_res  = w_rext[WIDTH:1];
                w_c    = w_rext[0];
            end
        endcase
    end

    // Every accepted request completes on the capturing edge
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_result <= '0;
            r_flags  <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= START;
            if (START) begin
                r_result <= w_res;
                r_flags  <= f_flags(w_res, w_c, w_v);
            end
        end
    end

    assign BUSY = 1'b0;

`else

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    // One-bit shift step: returns {bit shifted out, shifted value}
    function automatic logic [WIDTH:0] f_step(input logic [2:0]       op,
                                              input logic [WIDTH-1:0] val);
        case (op)
            c_OP_SLL: f_step = {val[WIDTH-1], val[WIDTH-2:0], 1'b0};
            c_OP_SRA: f_step = {val[0], val[WIDTH-1], val[WIDTH-1:1]};
            default:  f_step = {val[0], 1'b0, val[WIDTH-1:1]};
        endcase
    endfunction

    state_t           r_state;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_work;
    logic [2:0]       r_op;
    logic             w_is_shift;
    logic [WIDTH:0]   w_step;
    logic [WIDTH:0]   w_first;

    assign w_is_shift = ALUSEL[2] && (ALUSEL != c_OP_XOR);
    assign w_first    = f_step(ALUSEL, A);
    assign w_step     = f_step(r_op, r_work);

    // Result of the capturing edge; for long shifts this is the first step
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (ALUSEL)
            c_OP_AND: w_res = A & B;
            c_OP_OR:  w_res = A | B;
            c_OP_XOR: w_res = A ^ B;
            c_OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_c   = w_diff[WIDTH];
                w_v   = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
            end
            default: begin
                if (w_n == '0) begin
                    w_res = A;
                end else begin
                    w_res = w_first[WIDTH-1:0];
                    w_c   = w_first[WIDTH];
                end
            end
        endcase
    end

    // Control FSM: capture in IDLE, step the work register in SHIFT
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_work   <= '0;
            r_op     <= '0;
            r_result <= '0;
            r_flags  <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_op <= ALUSEL;
                        if (w_is_shift && (w_n > SHW'(1))) begin
                            r_work  <= w_res;
                            r_cnt   <= w_n - SHW'(1);
                            r_state <= S_SHIFT;
                        end else begin
                            r_result <= w_res;
                            r_flags  <= f_flags(w_res, w_c, w_v);
                            r_done   <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    r_work <= w_step[WIDTH-1:0];
                    r_cnt  <= r_cnt - SHW'(1);
                    // Final step: publish the result and the last bit out
                    if (r_cnt == SHW'(1)) begin
                        r_result <= w_step[WIDTH-1:0];
                        r_flags  <= f_flags(w_step[WIDTH-1:0], w_step[WIDTH], 1'b0);
                        r_done   <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign BUSY = (r_state == S_SHIFT);

`endif

    assign DONE   = r_done;
    assign ALUOut = r_result;
    assign FLAGS  = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq_unit
//  Description : Scoreboard bench for alu_seq_unit. Driver pushes expected
//                result/flags/latency per accepted request; a negedge monitor
//                pops and compares on every DONE.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_unit;

    localparam int W = 32;
    localparam int N_RAND = 250;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRA = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

`ifdef ALU_FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         RST;
    logic         START;
    logic [2:0]   ALUSEL;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] ALUOut;
    logic [3:0]   FLAGS;

    alu_seq_unit #(.WIDTH(W)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .START  (START),
        .ALUSEL (ALUSEL),
        .A      (A),
        .B      (B),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .ALUOut (ALUOut),
        .FLAGS  (FLAGS)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   flg;
        int           issue_cyc;
        int           lat;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   chk_cnt = 0;
    int   pass_cnt = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: plain integer arithmetic on the operation definitions
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t                e;
        longint unsigned     ua, ub;
        longint              sa, sb, sr;
        longint              maxs, mins;
        logic signed [W-1:0] as;
        logic [W-1:0]        r;
        logic                c, v;
        int                  n;
        ua   = a;
        ub   = b;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        maxs = (longint'(1) <<< (W - 1)) - 1;
        mins = -(longint'(1) <<< (W - 1));
        as   = a;
        n    = int'(ub % W);
        r = '0; c = 1'b0; v = 1'b0;
        case (op)
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_ADD: begin
                r  = W'(ua + ub);
                c  = ((ua + ub) >> W) != 0;
                sr = sa + sb;
                v  = (sr > maxs) || (sr < mins);
            end
            OP_SUB: begin
                r  = a - b;
                c  = (ua >= ub);
                sr = sa - sb;
                v  = (sr > maxs) || (sr < mins);
            end
            OP_SLL: begin
                r = a << n;
                c = (n == 0) ? 1'b0 : a[W - n];
            end
            OP_SRA: begin
                r = as >>> n;
                c = (n == 0) ? 1'b0 : a[n - 1];
            end
            default: begin
                r = a >> n;
                c = (n == 0) ? 1'b0 : a[n - 1];
            end
        endcase
        e.res = r;
        e.flg = {r[W-1], (r == '0), c, v};
        e.issue_cyc = 0;
        if (!FAST && (op == OP_SLL || op == OP_SRA || op == OP_SRL) && n >= 2) e.lat = n;
        else e.lat = 1;
        return e;
    endfunction

    // Monitor: every DONE cycle must match the oldest outstanding request
    always @(negedge CLK) begin
        exp_t e;
        if (DONE === 1'b1) begin
            if (sbq.size() == 0) begin
                check("unexpected_done", DONE, 1'b0);
            end else begin
                e = sbq.pop_front();
                check("result", ALUOut, e.res);
                check("flags", FLAGS, e.flg);
                check("latency", cyc - e.issue_cyc, e.lat);
            end
        end
    end

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   guard = 0;
        while (BUSY === 1'b1 && guard < 100) begin
            step();
            guard++;
        end
        if (guard >= 100) check("busy_timeout", BUSY, 1'b0);
        START  = 1'b1;
        ALUSEL = op;
        A      = a;
        B      = b;
        e = model(op, a, b);
        e.issue_cyc = cyc;
        sbq.push_back(e);
        step();
        START  = 1'b0;
        ALUSEL = 3'($urandom);
        A      = $urandom;
        B      = $urandom;
    endtask

    // Assert START with junk operands only while the unit is busy
    task automatic poke();
        if (BUSY === 1'b1) begin
            START  = 1'b1;
            ALUSEL = 3'($urandom);
            A      = $urandom;
            B      = $urandom;
            step();
            START  = 1'b0;
        end else begin
            step();
        end
    endtask

    task automatic do_reset(input int cycles, input bit with_start);
        RST   = 1'b1;
        START = with_start;
        if (with_start) begin
            ALUSEL = OP_ADD;
            A      = $urandom;
            B      = $urandom;
        end
        sbq.delete();
        repeat (cycles) step();
        RST   = 1'b0;
        START = 1'b0;
        check("rst_aluout", ALUOut, '0);
        check("rst_flags", FLAGS, 4'b0000);
        check("rst_done", DONE, 1'b0);
        check("rst_busy", BUSY, 1'b0);
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((sbq.size() != 0 || BUSY === 1'b1) && guard < 200) begin
            step();
            guard++;
        end
        if (guard >= 200) check("drain_timeout", sbq.size(), 0);
    endtask

    task automatic count_busy(output int nb);
        int guard = 0;
        nb = 0;
        while (DONE !== 1'b1 && guard < 100) begin
            if (BUSY === 1'b1) nb++;
            step();
            guard++;
        end
        if (guard >= 100) check("done_timeout", DONE, 1'b1);
    endtask

    initial begin
        int           nb;
        logic [2:0]   rop;
        logic [W-1:0] ra, rb;
        RST = 1'b1; START = 1'b0; ALUSEL = '0; A = '0; B = '0;
        step();
        do_reset(2, 1'b0);

        // ADD signed overflow
        issue(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        check("add_ovf_result", ALUOut, 32'h8000_0000);
        check("add_ovf_flags", FLAGS, 4'b1001);
        wait_idle();

        // SUB equal operands then back-to-back AND
        issue(OP_SUB, 32'd5, 32'd5);
        check("sub_eq_flags", FLAGS, 4'b0110);
        issue(OP_AND, 32'h0000_F0F0, 32'h0000_0FF0);
        check("b2b_done", DONE, 1'b1);
        check("b2b_and", ALUOut, 32'h0000_00F0);
        wait_idle();

        // SRA by 4: busy cycles and sign fill
        issue(OP_SRA, 32'h8000_0000, 32'd4);
        count_busy(nb);
        check("sra_busy_cycles", nb, FAST ? 0 : 3);
        check("sra_result", ALUOut, 32'hF800_0000);
        wait_idle();

        // SLL by 31 with START re-asserted while busy
        issue(OP_SLL, 32'h0000_0001, 32'd31);
        repeat (40) poke();
        wait_idle();
        check("sll31_result", ALUOut, 32'h8000_0000);

        // Same shift, aborted by reset mid-flight, then START lost to RST
        issue(OP_SLL, 32'h0000_0001, 32'd31);
        repeat (9) step();
        do_reset(2, 1'b0);
        do_reset(1, 1'b1);
        step();
        check("rst_start_lost", DONE, 1'b0);

        // SRL by 31
        issue(OP_SRL, 32'h8000_0000, 32'd31);
        count_busy(nb);
        check("srl31_busy_cycles", nb, FAST ? 0 : 30);
        check("srl31_result", ALUOut, 32'h0000_0001);
        wait_idle();

        // Randomized traffic with corner operands and busy-time pokes
        for (int i = 0; i < N_RAND; i++) begin
            rop = 3'($urandom);
            case ($urandom_range(0, 4))
                0: ra = 32'h8000_0000;
                1: ra = 32'h7FFF_FFFF;
                2: ra = 32'hFFFF_FFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0: rb = ($urandom & ~32'h1F) | 32'($urandom_range(0, 2));
                1: rb = ra;
                2: rb = 32'($urandom_range(0, 1));
                default: rb = $urandom;
            endcase
            issue(rop, ra, rb);
            repeat ($urandom_range(0, 2)) poke();
        end
        wait_idle();
        check("queue_empty", sbq.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_seq_unit.md
# alu_seq_unit

- Parametrised, registered ALU that replaces the purely combinational ALU output mux.
- Operands and operation select are captured on a start strobe.
- Add, subtract and logic ops finish in one cycle; shifts run iteratively, one bit per cycle, unless the fast-shift option is compiled in.
- The block returns a registered result, NZCV flags and a one-cycle done pulse; it sits between the register-file read stage and writeback in the datapath.

## Interface
Parameters:
- WIDTH, 32, operand/result width; power of two, >= 8
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)

Ports (one clock; reset is synchronous and active-high):
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- START  in  1  request strobe; sampled only when BUSY=0
- ALUSEL  in  3  operation: 000 AND, 001 OR, 010 SUB, 011 ADD, 100 SLL, 101 SRA, 110 SRL, 111 XOR
- A  in  WIDTH  operand A / value to shift
- B  in  WIDTH  operand B; for shifts, shift amount = B[SHW-1:0], upper bits ignored
- BUSY  out  1  high while an iterative shift is in progress
- DONE  out  1  one-cycle pulse: ALUOut/FLAGS updated this cycle
- ALUOut  out  WIDTH  registered result, held until the next completion
- FLAGS  out  4  {N,Z,C,V}, registered with ALUOut

## Operation
- States: IDLE, SHIFT. BUSY = (state==SHIFT).
- IDLE, START=1, edge E0: A, B and ALUSEL are captured.
  - Non-shift op, or shift with n = B[SHW-1:0] <= 1: ALUOut and FLAGS are written at E0, DONE=1 for the following cycle, and the state stays IDLE.
  - Shift with n >= 2: the work register is loaded with A shifted by 1, cnt = n-1, and the state goes to SHIFT.
- SHIFT, each edge: shift the work register by 1 and decrement cnt. The edge on which cnt==1 writes ALUOut/FLAGS, pulses DONE and returns to IDLE.
- START while BUSY=1 is ignored; there is no queueing. START in a cycle where DONE=1 (state IDLE) is accepted.
- ALUSEL, A and B changing during SHIFT have no effect; the captured values are used.
- SLL fills with 0. SRL fills with 0. SRA replicates the captured A[WIDTH-1].
- All eight ALUSEL codes are defined; there is no latch and no hold on an undefined code.
- Arithmetic is modulo 2^WIDTH. SUB = A + ~B + 1.
- Flags:
  - N = result[WIDTH-1]
  - Z = (result==0)
  - ADD: C = carry-out
  - SUB: C = 1 when there is no borrow (A >= B unsigned)
  - ADD/SUB: V = signed overflow
  - Shifts with n >= 1: C = last bit shifted out. For n = 0, C = 0.
  - AND/OR/XOR: C = 0
  - V = 0 for all non-ADD/SUB ops.

## Timing
- Latency from the START-sampling edge to the DONE cycle: 1 cycle for non-shift ops and for shifts with n <= 1; n cycles for shifts with n >= 2. Maximum is WIDTH-1.
- Back-to-back single-cycle ops: throughput is 1 per cycle, and DONE stays high continuously.
- After a shift, BUSY falls on the same edge DONE rises. A new START is accepted that cycle.
- Reset values: state IDLE, ALUOut = 0, FLAGS = 0000, DONE = 0, BUSY = 0, cnt = 0.
- RST has priority over START and over an in-flight shift. Mid-shift reset aborts the shift with no DONE, and the partial result is discarded.
- START and RST asserted in the same cycle: reset wins and the request is lost.

## Configuration
- ALU_FAST_SHIFT_EN defined: shifts use a single-cycle barrel shifter. The SHIFT state and counter are compiled out, all ops have latency 1, and BUSY is tied 0. Flag rules are unchanged (C = last bit shifted out).
- Undefined: iterative shifter as described above.

## Test plan
- Reset: RST=1 for 2 cycles mid-activity -> ALUOut=0, FLAGS=0000, DONE=0, BUSY=0.
- ADD with WIDTH=32: A=0x7FFFFFFF, B=1 -> next cycle DONE=1, ALUOut=0x80000000, FLAGS N=1 Z=0 C=0 V=1.
- SUB, then back-to-back ops: SUB A=5, B=5 -> ALUOut=0, Z=1, C=1. The next cycle, START with AND A=0xF0F0, B=0x0FF0 -> ALUOut=0x00F0, and DONE stays high for both cycles.
- SRA: A=0x80000000, B=4 -> BUSY high for 3 cycles, then DONE in cycle 4 with ALUOut=0xF8000000, N=1, C=0. Bench measures the latency.
- START ignored and mid-shift reset: SLL A=1, B=31, with START re-asserted (XOR) during BUSY -> the re-asserted START is ignored and the result is ALUOut=0x80000000 after 31 cycles. Repeat with RST pulsed at cycle 10 -> no DONE, outputs zeroed.
- With ALU_FAST_SHIFT_EN: SRL A=0x80000000, B=31 -> DONE next cycle, ALUOut=1, BUSY never asserted.
